instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide TIMEOUT, default 8: the maximum number of cycles spent waiting for cpu_done before the block advances anyway.
REQ-002 SHALL provide GAP, default 2: the number of idle cycles between instructions in run mode.

Ports (name, direction, width, meaning):
REQ-003 SHALL have `clk`, input, 1: the single clock.
REQ-004 SHALL have `rst`, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have `load_we`, input, 1: one-cycle pulse that writes `load_word` to `load_addr`.
REQ-006 SHALL have `load_addr`, input, 4: program-memory write address.
REQ-007 SHALL have `load_word`, input, 16: {order[7:0], data[7:0]}.
REQ-008 SHALL have `start`, input, 1: one-cycle pulse that begins execution at PC 0.
REQ-009 SHALL have `step`, input, 1: one-cycle pulse that issues the next instruction in single-step mode.
REQ-010 SHALL have `run_mode`, input, 1: 1 selects continuous execution, 0 selects single-step.
REQ-011 SHALL have `cpu_done`, input, 1: instruction-complete level from the downstream CPU controller.
REQ-012 SHALL have `order`, output, 8: instruction byte driven to the CPU.
REQ-013 SHALL have `data`, output, 8: operand byte driven to the CPU.
REQ-014 SHALL have `w`, output, 1: one-cycle issue strobe to the CPU.
REQ-015 SHALL have `pc`, output, 4: index of the current instruction.
REQ-016 SHALL have `busy`, output, 1: high in any state other than IDLE and HALT.
REQ-017 SHALL have `halted`, output, 1: high in the HALT state.

Function
REQ-018 SHALL contain a 16x16 program memory, written at the `clk` edge when `load_we`=1 and state is IDLE or HALT; `load_we` while busy is ignored.
REQ-019 SHALL implement the states IDLE, FETCH, ISSUE, WAIT, ADVANCE, GAPW, PAUSE and HALT.
REQ-020 SHALL, on `start` in IDLE or HALT: set pc=0 and go to FETCH; `start` while busy is ignored.
REQ-021 SHALL, in FETCH: register mem[pc] into {order,data}, then go to ISSUE; if opcode order[7:4]==4'b1110 (HALT), go to HALT instead, with no `w` pulse.
REQ-022 SHALL, in ISSUE: drive `w`=1 for exactly one cycle, then go to WAIT; order/data are stable at least one cycle before `w` and held until the next FETCH.
REQ-023 SHALL, in WAIT: advance on the first cycle with `cpu_done`=1, or after TIMEOUT cycles without it (covers the CPU Show op, which never raises Done); the counter clears on WAIT entry.
REQ-024 SHALL, in ADVANCE: if pc==15, go to HALT with no wrap; otherwise pc<=pc+1, then go to GAPW if `run_mode`=1, else to PAUSE.
REQ-025 SHALL, in GAPW: wait GAP cycles, then go to FETCH.
REQ-026 SHALL, in PAUSE: go to FETCH on `step`; `step` in any other state is ignored.
REQ-027 SHALL make latency from `start` sampled at edge k to `w`=1 equal to the cycle following edge k+2.
REQ-028 SHALL, when `load_we` and `start` coincide in IDLE: commit the write, and the subsequent FETCH reads the new word.
REQ-029 SHALL sample `run_mode` only in ADVANCE; changes at other times take effect at the next ADVANCE.

Reset
REQ-030 SHALL, on `rst`=0 at a `clk` edge, from any state including mid-WAIT: state=IDLE, pc=0, order=0, data=0, w=0, busy=0, halted=0, counters=0.
REQ-031 SHALL NOT clear program-memory contents on reset.

Structure
REQ-032 SHALL place the state encoding, the HALT opcode 4'b1110 and the CPU opcodes (Load 0000, Move 0001, Add 0010, Sub 0011, Show 1111) in a shared package.
REQ-033 SHALL use one sub-module, prog_mem (16x16, synchronous write, asynchronous read); the FSM lives in instr_sequencer.

Verification
REQ-034 SHALL cover load: write 0x0002 @0, 0x0405 @1, 0xE000 @2; start, run_mode=1, cpu_done pulsed 2 cycles after each w -> exactly two w pulses with order/data 00/02 then 04/05, then halted=1 and pc=2.
REQ-035 SHALL cover timeout: program F300 @0, E000 @1, cpu_done held 0 -> w at 0xF3, advance after exactly 8 WAIT cycles, then HALT.
REQ-036 SHALL cover single-step: run_mode=0, 3-instruction program -> one w per step pulse; step pulses during WAIT produce no extra w.
REQ-037 SHALL cover PC end: 16 non-halt words, run_mode=1 -> 16 w pulses, halted=1, pc=15, no wrap to 0.
REQ-038 SHALL cover reset mid-op: rst=0 during WAIT -> next cycle all outputs zero, state IDLE; restart reproduces the same sequence because memory is retained.
REQ-039 SHALL cover load guard: load_we while busy -> memory unchanged, verified by re-running the program.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer_pkg
//  Description : Shared types and constants for the instruction sequencer.
//                These are the FSM state encoding, the program-memory
//                geometry, the sequencer HALT opcode and the opcodes
//                understood by the downstream CPU controller.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package instr_sequencer_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W     = 4;
    localparam int WORD_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_GAPW    = 3'd5,
        S_PAUSE   = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    // Opcode lives in order[7:4]
    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MOVE = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SHOW = 4'b1111;
    localparam logic [3:0] OP_HALT = 4'b1110;

    function automatic logic is_halt(input logic [7:0] order_byte);
        return order_byte[7:4] == OP_HALT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer_if
//  Description : Bus bundle between the program loader/controller and the
//                instruction sequencer, including the CPU-facing side.
//  Ports       : load_we/load_addr/load_word - program load
//                start/step/run_mode         - execution control
//                cpu_done                    - completion from CPU
//                order/data/w                - instruction issue to CPU
//                pc/busy/halted              - status
//  Modports    : master (drives control, observes status), slave (sequencer)
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_sequencer_if;
    import instr_sequencer_pkg::*;

    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [WORD_W-1:0] load_word;
    logic              start;
    logic              step;
    logic              run_mode;
    logic              cpu_done;
    logic [7:0]        order;
    logic [7:0]        data;
    logic              w;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    modport master (
        output load_we, load_addr, load_word, start, step, run_mode, cpu_done,
        input  order, data, w, pc, busy, halted
    );

    modport slave (
        input  load_we, load_addr, load_word, start, step, run_mode, cpu_done,
        output order, data, w, pc, busy, halted
    );

endinterface
`default_nettype wire

// File: rtl/instr_sequencer_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem
//  Description : 16x16 program memory, synchronous write, asynchronous read.
//                Contents are deliberately not reset so a program survives
//                a sequencer reset.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                raddr - read address
//                rdata - read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module prog_mem
    import instr_sequencer_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [WORD_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Steps through a 16-entry program, issuing {order,data} to a
//                CPU controller with a one-cycle w strobe, waiting for
//                cpu_done (or a timeout), then advancing in run or
//                single-step mode. Opcode 1110 halts the sequence.
//  Parameters  : TIMEOUT - max WAIT cycles without cpu_done
//                GAP     - idle cycles between instructions in run mode
//  Ports       : clk - clock
//                rst - synchronous active-low reset
//                bus - instr_sequencer_if.slave (load, control, issue, status)
//  Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int GAP     = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    instr_sequencer_if.slave   bus
);

    localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [ADDR_W-1:0] PC_LAST      = ADDR_W'(PROG_DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        order;
    logic [7:0]        data;
    logic              w;
    logic [WORD_W-1:0] mem_word;
    logic              mem_we;

    // Loading is only legal while nothing is executing
    assign mem_we = bus.load_we && ((state == S_IDLE) || (state == S_HALT));

    prog_mem u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.load_addr),
        .wdata (bus.load_word),
        .raddr (pc),
        .rdata (mem_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
            order <= '0;
            data  <= '0;
            w     <= 1'b0;
        end else begin
            w <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Operands are registered a full cycle ahead of w
                    order <= mem_word[15:8];
                    data  <= mem_word[7:0];
                    state <= is_halt(mem_word[15:8]) ? S_HALT : S_ISSUE;
                end
                S_ISSUE: begin
                    w     <= 1'b1;
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // The timeout also covers Show, which never raises done
                    if (bus.cpu_done || (cnt == TIMEOUT_LAST)) begin
                        state <= S_ADVANCE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ADVANCE: begin
                    if (pc == PC_LAST) begin
                        state <= S_HALT;
                    end else begin
                        pc  <= pc + ADDR_W'(1);
                        cnt <= '0;
                        if (bus.run_mode) begin
                            state <= (GAP == 0) ? S_FETCH : S_GAPW;
                        end else begin
                            state <= S_PAUSE;
                        end
                    end
                end
                S_GAPW: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_FETCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.step) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status flags are plain decodes of the state register
    assign bus.order  = order;
    assign bus.data   = data;
    assign bus.w      = w;
    assign bus.pc     = pc;
    assign bus.busy   = (state != S_IDLE) && (state != S_HALT);
    assign bus.halted = (state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Directed self-checking bench for instr_sequencer
//                (TIMEOUT=8, GAP=2). Expected values are hand-computed.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    instr_sequencer_if bus ();

    instr_sequencer #(
        .TIMEOUT (8),
        .GAP     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    int cyc;
    int cd;
    int done_dly;
    int pc1_cyc;
    int halt_cyc;

    logic [7:0] ord_q [$];
    logic [7:0] dat_q [$];
    logic [3:0] pcw_q [$];
    int         wcyc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; logs w strobes and plays the CPU (done done_dly cycles after w)
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.cpu_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) bus.cpu_done = 1'b1;
        end
        if (bus.w) begin
            ord_q.push_back(bus.order);
            dat_q.push_back(bus.data);
            pcw_q.push_back(bus.pc);
            wcyc_q.push_back(cyc);
            if (done_dly > 0) begin
                cd = done_dly - 1;
                if (cd == 0) bus.cpu_done = 1'b1;
            end
        end
        if (pc1_cyc < 0 && bus.pc == 4'd1) pc1_cyc = cyc;
        if (halt_cyc < 0 && bus.halted) halt_cyc = cyc;
    endtask

    task automatic clear_log();
        ord_q.delete();
        dat_q.delete();
        pcw_q.delete();
        wcyc_q.delete();
        cyc      = 0;
        cd       = -1;
        pc1_cyc  = -1;
        halt_cyc = -1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [15:0] wd);
        bus.load_we   = 1'b1;
        bus.load_addr = a;
        bus.load_word = wd;
        tick();
        bus.load_we   = 1'b0;
    endtask

    task automatic run_prog(input int dly, input int max_cyc);
        clear_log();
        done_dly  = dly;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!bus.halted && cyc < max_cyc) tick();
        check("run_to_halt", 32'(bus.halted), 32'd1);
    endtask

    task automatic wait_w(input int n, input int max_cyc);
        int lim;
        lim = cyc + max_cyc;
        while (ord_q.size() < n && cyc < lim) tick();
        check("w_seen", ord_q.size(), n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_order"},  32'(bus.order),  32'd0);
        check({tag, "_data"},   32'(bus.data),   32'd0);
        check({tag, "_w"},      32'(bus.w),      32'd0);
        check({tag, "_pc"},     32'(bus.pc),     32'd0);
        check({tag, "_busy"},   32'(bus.busy),   32'd0);
        check({tag, "_halted"}, 32'(bus.halted), 32'd0);
    endtask

    initial begin
        bus.load_we   = 1'b0;
        bus.load_addr = '0;
        bus.load_word = '0;
        bus.start     = 1'b0;
        bus.step      = 1'b0;
        bus.run_mode  = 1'b1;
        bus.cpu_done  = 1'b0;
        done_dly      = 0;
        clear_log();

        // Reset state
        tick();
        tick();
        check_zero("reset");
        rst = 1'b1;

        // Basic run: two instructions then HALT
        load_word(4'd0, 16'h0002);
        load_word(4'd1, 16'h0405);
        load_word(4'd2, 16'hE000);
        bus.run_mode = 1'b1;
        run_prog(2, 200);
        check("basic_nw", ord_q.size(), 2);
        if (ord_q.size() >= 2) begin
            check("basic_latency", wcyc_q[0], 3);
            check("basic_w1_cyc",  wcyc_q[1], 10);
            check("basic_ord0",    ord_q[0], 8'h00);
            check("basic_dat0",    dat_q[0], 8'h02);
            check("basic_ord1",    ord_q[1], 8'h04);
            check("basic_dat1",    dat_q[1], 8'h05);
            check("basic_pcw1",    pcw_q[1], 4'd1);
        end
        check("basic_halt_cyc", halt_cyc, 16);
        check("basic_pc", bus.pc, 4'd2);
        check("basic_busy", bus.busy, 1'b0);

        // Timeout: Show op, cpu_done never raised
        load_word(4'd0, 16'hF300);
        load_word(4'd1, 16'hE000);
        run_prog(0, 200);
        check("tmo_nw", ord_q.size(), 1);
        if (ord_q.size() >= 1) begin
            check("tmo_ord", ord_q[0], 8'hF3);
            check("tmo_dat", dat_q[0], 8'h00);
            check("tmo_advance_delay", pc1_cyc - wcyc_q[0], 9);
            check("tmo_halt_delay", halt_cyc - wcyc_q[0], 12);
        end
        check("tmo_pc", bus.pc, 4'd1);

        // Single-step
        load_word(4'd0, 16'h0102);
        load_word(4'd1, 16'h1203);
        load_word(4'd2, 16'h2304);
        load_word(4'd3, 16'hE000);
        bus.run_mode = 1'b0;
        clear_log();
        done_dly  = 2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_w(1, 10);
        bus.step = 1'b1;   // lands in WAIT, must be ignored
        tick();
        bus.step = 1'b0;
        repeat (15) tick();
        check("ss_wait_step_nw", ord_q.size(), 1);
        check("ss_pause_pc", bus.pc, 4'd1);
        check("ss_pause_busy", bus.busy, 1'b1);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (15) tick();
        check("ss_nw2", ord_q.size(), 2);
        if (ord_q.size() >= 2) begin
            check("ss_ord1", ord_q[1], 8'h12);
            check("ss_dat1", dat_q[1], 8'h03);
        end
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (15) tick();
        check("ss_nw3", ord_q.size(), 3);
        if (ord_q.size() >= 3) check("ss_ord2", ord_q[2], 8'h23);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (15) tick();
        check("ss_halted", bus.halted, 1'b1);
        check("ss_nw_final", ord_q.size(), 3);
        check("ss_pc", bus.pc, 4'd3);

        // PC end: 16 non-halt words, no wrap
        for (int i = 0; i < 16; i++) begin
            load_word(4'(i), {4'(i % 4), 4'(i), 8'(8'h10 + i)});
        end
        bus.run_mode = 1'b1;
        run_prog(2, 600);
        check("end_nw", ord_q.size(), 16);
        if (ord_q.size() >= 16) begin
            check("end_ord0",  ord_q[0],  8'h00);
            check("end_dat0",  dat_q[0],  8'h10);
            check("end_ord15", ord_q[15], 8'h3F);
            check("end_dat15", dat_q[15], 8'h1F);
            check("end_pcw15", pcw_q[15], 4'd15);
        end
        check("end_pc", bus.pc, 4'd15);

        // Reset during WAIT, then rerun from retained memory
        clear_log();
        done_dly  = 2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_w(2, 40);
        rst = 1'b0;
        tick();
        check_zero("midrst");
        rst = 1'b1;
        run_prog(2, 600);
        check("midrst_nw", ord_q.size(), 16);
        if (ord_q.size() >= 16) begin
            check("midrst_ord5", ord_q[5], 8'h15);
            check("midrst_dat5", dat_q[5], 8'h15);
        end
        check("midrst_pc", bus.pc, 4'd15);

        // Load coincident with start in IDLE, then load while busy
        rst = 1'b0;
        tick();
        rst = 1'b1;
        load_word(4'd1, 16'h0405);
        load_word(4'd2, 16'hE000);
        clear_log();
        done_dly      = 2;
        bus.load_we   = 1'b1;
        bus.load_addr = 4'd0;
        bus.load_word = 16'h3377;
        bus.start     = 1'b1;
        tick();
        bus.load_we   = 1'b0;
        bus.start     = 1'b0;
        wait_w(1, 10);
        if (ord_q.size() >= 1) begin
            check("coinc_ord", ord_q[0], 8'h33);
            check("coinc_dat", dat_q[0], 8'h77);
        end
        bus.load_we   = 1'b1;
        bus.load_addr = 4'd1;
        bus.load_word = 16'hAAAA;
        tick();
        bus.load_we   = 1'b0;
        while (!bus.halted && cyc < 200) tick();
        check("guard_nw", ord_q.size(), 2);
        if (ord_q.size() >= 2) check("guard_ord1_same_run", ord_q[1], 8'h04);
        run_prog(2, 200);
        check("guard_rerun_nw", ord_q.size(), 2);
        if (ord_q.size() >= 2) begin
            check("guard_rerun_ord0", ord_q[0], 8'h33);
            check("guard_rerun_ord1", ord_q[1], 8'h04);
            check("guard_rerun_dat1", dat_q[1], 8'h05);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
